seq_control_unit: RTL and testbench

Parametrised multi-cycle instruction sequencer for the 8-bit MCU datapath. It drives the same datapath strobes as the current control unit and adds:
- ready/wait handshakes for memory and I/O;
- a conditional JNZ driven by the zero flag;
- a true HALT state;
- illegal-opcode detection;
- a bus-timeout fault.

It sits between the instruction register/flags and the register file, ALU, PC and bus interface.

---
 rtl/mcu_pkg.sv | 71 +++++++
 rtl/wait_timer.sv | 29 ++
 rtl/seq_control_unit.sv | 219 +++++++++++++++++++++
 tb/tb_seq_control_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the 8-bit MCU: opcodes, ALU operations, write-back
// source selects and the sequencer state set.
package mcu_pkg;

    // Instruction opcodes (4-bit space; wider IR codes beyond 15 are illegal)
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_DEC   = 4'd6;
    localparam logic [3:0] OP_MOV   = 4'd7;
    localparam logic [3:0] OP_LDI   = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd10;
    localparam logic [3:0] OP_IN    = 4'd11;
    localparam logic [3:0] OP_OUT   = 4'd12;
    localparam logic [3:0] OP_JMP   = 4'd13;
    localparam logic [3:0] OP_JNZ   = 4'd14;
    localparam logic [3:0] OP_HLT   = 4'd15;

    // ALU operation codes
    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_DEC  = 4'd6;

    // Write-back source selects
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IO  = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_MEM_RD,
        S_MEM_WR,
        S_IO,
        S_HALT
    } state_e;

    // Register-register/immediate ALU class, all executed through EXEC
    function automatic logic is_alu_class(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_DEC) ||
               (op == OP_MOV);
    endfunction

    // ALU operation for an ALU-class opcode; MOV passes the operand through
    function automatic logic [3:0] alu_code(input logic [3:0] op);
        logic [3:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_XOR:  code = ALU_XOR;
            OP_DEC:  code = ALU_DEC;
            default: code = ALU_PASS;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Bus wait counter: cleared whenever the sequencer is not stalled on a
// request, counts stalled cycles and flags when the tolerance is used up.
module wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

    logic [CW-1:0] count;

    assign expired = (count == LIMIT);

    // Count stalled cycles; hold at the limit (the sequencer leaves anyway)
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer for the 8-bit MCU datapath. All strobes
// are combinational from state and inputs; the datapath acts on the next edge.
module seq_control_unit
    import mcu_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int ALU_OP_W = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     opcode,
    input  logic                imm_mode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    input  logic                io_ready,
    output logic                reg_write,
    output logic                load_a,
    output logic                load_b,
    output logic                load_c,
    output logic                load_ir,
    output logic                load_flags,
    output logic                load_data_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                load_pc,
    output logic                inc_pc,
    output logic                pc_sel,
    output logic                b_imm_sel,
    output logic [1:0]          mux1_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                io_enable,
    output logic                io_write_enable,
    output logic                halted,
    output logic                illegal_op,
    output logic                bus_err
);

    state_e     state, next_state;
    logic [1:0] wb_sel, next_wb_sel;
    logic       err_sticky;
    logic [3:0] op;
    logic       op_bad;
    logic       waiting, ready, stall, expired, timeout;

    // Any IR bits above the 4-bit opcode space make the instruction illegal
    generate
        if (OP_W > 4) begin : g_wide_op
            assign op_bad = |opcode[OP_W-1:4];
        end else begin : g_narrow_op
            assign op_bad = 1'b0;
        end
    endgenerate

    assign op = opcode[3:0];

    // States that hold a request until the bus answers
    assign waiting = (state == S_FETCH) || (state == S_MEM_RD) ||
                     (state == S_MEM_WR) || (state == S_IO);
    assign ready   = (state == S_IO) ? io_ready : mem_ready;
    assign stall   = waiting && !ready;
    assign timeout = stall && expired;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!stall),
        .inc     (stall),
        .expired (expired)
    );

    // Next-state and write-back source selection
    always_comb begin
        next_state  = state;
        next_wb_sel = wb_sel;
        case (state)
            S_FETCH: begin
                if (timeout)        next_state = S_HALT;
                else if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                if (op_bad) begin
                    next_state = S_FETCH;
                end else if (is_alu_class(op)) begin
                    next_state = S_EXEC;
                end else begin
                    case (op)
                        OP_HLT:   next_state = S_HALT;
                        OP_LDI: begin
                            next_state  = S_WB;
                            next_wb_sel = WB_IMM;
                        end
                        OP_LOAD:  next_state = S_MEM_RD;
                        OP_STORE: next_state = S_MEM_WR;
                        OP_IN,
                        OP_OUT:   next_state = S_IO;
                        default:  next_state = S_FETCH;
                    endcase
                end
            end
            S_EXEC: begin
                next_state  = S_WB;
                next_wb_sel = WB_ALU;
            end
            S_WB: next_state = S_FETCH;
            S_MEM_RD: begin
                if (timeout) begin
                    next_state = S_HALT;
                end else if (mem_ready) begin
                    next_state  = S_WB;
                    next_wb_sel = WB_MEM;
                end
            end
            S_MEM_WR: begin
                if (timeout)        next_state = S_HALT;
                else if (mem_ready) next_state = S_FETCH;
            end
            S_IO: begin
                if (timeout) begin
                    next_state = S_HALT;
                end else if (io_ready) begin
                    if (op == OP_OUT) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state  = S_WB;
                        next_wb_sel = WB_IO;
                    end
                end
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // Datapath strobes; everything is held low while reset is asserted
    always_comb begin
        reg_write       = 1'b0;
        load_a          = 1'b0;
        load_b          = 1'b0;
        load_c          = 1'b0;
        load_ir         = 1'b0;
        load_flags      = 1'b0;
        load_data_reg   = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        load_pc         = 1'b0;
        inc_pc          = 1'b0;
        pc_sel          = 1'b0;
        b_imm_sel       = 1'b0;
        mux1_sel        = WB_ALU;
        alu_op          = '0;
        io_enable       = 1'b0;
        io_write_enable = 1'b0;
        halted          = 1'b0;
        illegal_op      = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    load_ir  = mem_ready;
                    inc_pc   = mem_ready;
                end
                S_DECODE: begin
                    if (op_bad) begin
                        illegal_op = 1'b1;
                    end else if (op == OP_JMP) begin
                        load_pc = 1'b1;
                        pc_sel  = imm_mode;
                    end else if (op == OP_JNZ) begin
                        load_pc = !zero_flag;
                        pc_sel  = imm_mode && !zero_flag;
                    end
                end
                S_EXEC: begin
                    load_a     = 1'b1;
                    load_b     = !imm_mode;
                    b_imm_sel  = imm_mode;
                    load_c     = 1'b1;
                    alu_op     = ALU_OP_W'(alu_code(op));
                    load_flags = (op != OP_MOV);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    mux1_sel  = wb_sel;
                end
                S_MEM_RD: begin
                    mem_read      = 1'b1;
                    load_data_reg = mem_ready;
                end
                S_MEM_WR: mem_write = 1'b1;
                S_IO: begin
                    io_enable       = 1'b1;
                    io_write_enable = (op == OP_OUT);
                    load_data_reg   = io_ready && (op != OP_OUT);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus_err = err_sticky && !reset;

    // State, latched write-back source and sticky bus fault
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            wb_sel     <= WB_ALU;
            err_sticky <= 1'b0;
        end else begin
            state  <= next_state;
            wb_sel <= next_wb_sel;
            if (timeout) err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: an instruction-level model expands each
// instruction into its expected per-cycle strobe vectors and ready stimulus.
module tb_seq_control_unit;
    import mcu_pkg::*;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] opcode = '0;
    logic       imm_mode = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0, io_ready = 1'b0;
    logic       reg_write, load_a, load_b, load_c, load_ir, load_flags, load_data_reg;
    logic       mem_read, mem_write, load_pc, inc_pc, pc_sel, b_imm_sel;
    logic [1:0] mux1_sel;
    logic [3:0] alu_op;
    logic       io_enable, io_write_enable, halted, illegal_op, bus_err;

    seq_control_unit #(.OP_W(5), .ALU_OP_W(4), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .imm_mode(imm_mode),
        .zero_flag(zero_flag), .mem_ready(mem_ready), .io_ready(io_ready),
        .reg_write(reg_write), .load_a(load_a), .load_b(load_b), .load_c(load_c),
        .load_ir(load_ir), .load_flags(load_flags), .load_data_reg(load_data_reg),
        .mem_read(mem_read), .mem_write(mem_write), .load_pc(load_pc),
        .inc_pc(inc_pc), .pc_sel(pc_sel), .b_imm_sel(b_imm_sel),
        .mux1_sel(mux1_sel), .alu_op(alu_op), .io_enable(io_enable),
        .io_write_enable(io_write_enable), .halted(halted),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic reg_write, load_a, load_b, load_c, load_ir, load_flags, load_data_reg;
        logic mem_read, mem_write, load_pc, inc_pc, pc_sel, b_imm_sel;
        logic [1:0] mux1_sel;
        logic [3:0] alu_op;
        logic io_enable, io_write_enable, halted, illegal_op, bus_err;
    } outs_t;

    typedef struct {
        logic       rst, mr, ir, imm, z;
        logic [4:0] op;
        outs_t      exp;
        int         id;
    } cyc_t;

    cyc_t       q[$];
    bit         m_err;
    int         n_pass = 0, n_chk = 0, cur_id = 0;
    logic [4:0] c_op = '0;
    logic       c_imm = 1'b0, c_z = 1'b0;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic outs_t base();
        outs_t o = '0;
        o.bus_err = m_err;
        return o;
    endfunction

    function automatic void push(outs_t e, logic mr, logic ir);
        cyc_t c;
        c.rst = 1'b0; c.mr = mr; c.ir = ir; c.op = c_op;
        c.imm = c_imm; c.z = c_z; c.exp = e; c.id = cur_id;
        q.push_back(c);
    endfunction

    function automatic void push_reset(int n);
        for (int i = 0; i < n; i++) begin
            push('0, rb(), rb());
            q[q.size()-1].rst = 1'b1;
        end
        m_err = 1'b0;
    endfunction

    function automatic void push_halted(int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = base();
            o.halted = 1'b1;
            push(o, rb(), rb());
        end
    endfunction

    // Bus access: 'waits' cycles without ready, then the ready cycle; more
    // waits than tolerated give WAIT_MAX+1 request cycles and a fault.
    function automatic bit access(bit io, int waits, outs_t req, outs_t done);
        for (int i = 0; i < waits && i <= WAIT_MAX; i++)
            push(req, io ? rb() : 1'b0, io ? 1'b0 : rb());
        if (waits > WAIT_MAX) begin
            m_err = 1'b1;
            return 1'b0;
        end
        push(done, io ? rb() : 1'b1, io ? 1'b1 : rb());
        return 1'b1;
    endfunction

    function automatic void wb(logic [1:0] src);
        outs_t o = base();
        o.reg_write = 1'b1;
        o.mux1_sel  = src;
        push(o, rb(), rb());
    endfunction

    // Expands one instruction; returns the number of cycles it occupies.
    // Ends in halt when the instruction is HLT or a bus fault occurs.
    function automatic int instr(logic [4:0] op, logic imm, logic z, int fw, int aw);
        int    start = q.size();
        outs_t req, done, d, e;
        cur_id++;
        c_op = op; c_imm = imm; c_z = z;
        req = base(); req.mem_read = 1'b1;
        done = req; done.load_ir = 1'b1; done.inc_pc = 1'b1;
        if (!access(1'b0, fw, req, done)) return q.size() - start;
        d = base();
        if (op[4]) begin
            d.illegal_op = 1'b1;
            push(d, rb(), rb());
            return q.size() - start;
        end
        push(d, rb(), rb());
        case (op[3:0])
            OP_JMP: begin
                q[q.size()-1].exp.load_pc = 1'b1;
                q[q.size()-1].exp.pc_sel  = imm;
            end
            OP_JNZ: begin
                q[q.size()-1].exp.load_pc = !z;
                q[q.size()-1].exp.pc_sel  = imm & !z;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DEC, OP_MOV: begin
                e = base();
                e.load_a = 1'b1; e.load_c = 1'b1;
                e.load_b = !imm; e.b_imm_sel = imm;
                case (op[3:0])
                    OP_ADD:  e.alu_op = 4'd1;
                    OP_SUB:  e.alu_op = 4'd2;
                    OP_AND:  e.alu_op = 4'd3;
                    OP_OR:   e.alu_op = 4'd4;
                    OP_XOR:  e.alu_op = 4'd5;
                    OP_DEC:  e.alu_op = 4'd6;
                    default: e.alu_op = 4'd0;
                endcase
                e.load_flags = (op[3:0] != OP_MOV);
                push(e, rb(), rb());
                wb(2'b00);
            end
            OP_LDI: wb(2'b11);
            OP_LOAD: begin
                req = base(); req.mem_read = 1'b1;
                done = req; done.load_data_reg = 1'b1;
                if (access(1'b0, aw, req, done)) wb(2'b01);
            end
            OP_STORE: begin
                req = base(); req.mem_write = 1'b1;
                void'(access(1'b0, aw, req, req));
            end
            OP_IN: begin
                req = base(); req.io_enable = 1'b1;
                done = req; done.load_data_reg = 1'b1;
                if (access(1'b1, aw, req, done)) wb(2'b10);
            end
            OP_OUT: begin
                req = base(); req.io_enable = 1'b1; req.io_write_enable = 1'b1;
                void'(access(1'b1, aw, req, req));
            end
            default: ;
        endcase
        return q.size() - start;
    endfunction

    task automatic check_eq(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drives each planned cycle and compares every DUT output against the plan
    task automatic run();
        cyc_t  c;
        outs_t a;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            reset = c.rst; mem_ready = c.mr; io_ready = c.ir;
            opcode = c.op; imm_mode = c.imm; zero_flag = c.z;
            @(negedge clk);
            a.reg_write = reg_write; a.load_a = load_a; a.load_b = load_b;
            a.load_c = load_c; a.load_ir = load_ir; a.load_flags = load_flags;
            a.load_data_reg = load_data_reg; a.mem_read = mem_read;
            a.mem_write = mem_write; a.load_pc = load_pc; a.inc_pc = inc_pc;
            a.pc_sel = pc_sel; a.b_imm_sel = b_imm_sel; a.mux1_sel = mux1_sel;
            a.alu_op = alu_op; a.io_enable = io_enable;
            a.io_write_enable = io_write_enable; a.halted = halted;
            a.illegal_op = illegal_op; a.bus_err = bus_err;
            n_chk++;
            if (a === c.exp) n_pass++;
            else $display("FAIL strobes instr %0d op %h rst %0b: got %h expected %h",
                          c.id, c.op, c.rst, a, c.exp);
        end
    endtask

    initial begin
        logic [3:0] legal [15];
        int         n, r;
        logic [4:0] op;
        outs_t      req;
        legal = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DEC, OP_MOV,
                  OP_LDI, OP_LOAD, OP_STORE, OP_IN, OP_OUT, OP_JMP, OP_JNZ};
        m_err = 1'b0;

        push_reset(3);
        n = instr(5'(OP_ADD), 1'b0, 1'b0, 0, 0);
        check_eq("add_cycles", n, 4);
        check_eq("add_exec_alu_op", int'(q[q.size()-2].exp.alu_op), 1);
        check_eq("add_exec_load_flags", int'(q[q.size()-2].exp.load_flags), 1);
        n = instr(5'(OP_JNZ), 1'b1, 1'b0, 0, 0);
        check_eq("jnz_taken_cycles", n, 2);
        check_eq("jnz_taken_load_pc", int'(q[q.size()-1].exp.load_pc), 1);
        n = instr(5'(OP_JNZ), 1'b1, 1'b1, 0, 0);
        check_eq("jnz_not_taken_cycles", n, 2);
        n = instr(5'(OP_LOAD), 1'b0, 1'b0, 0, 3);
        check_eq("load_wait3_cycles", n, 7);
        check_eq("ldi_cycles", instr(5'(OP_LDI), 1'b1, 1'b0, 0, 0), 3);
        check_eq("store_cycles", instr(5'(OP_STORE), 1'b0, 1'b0, 0, 0), 3);
        check_eq("out_cycles", instr(5'(OP_OUT), 1'b0, 1'b0, 0, 0), 3);
        check_eq("in_cycles", instr(5'(OP_IN), 1'b0, 1'b0, 0, 0), 4);
        check_eq("illegal_cycles", instr(5'h13, 1'b0, 1'b0, 0, 0), 2);
        check_eq("ready_at_limit_cycles",
                 instr(5'(OP_LOAD), 1'b0, 1'b0, WAIT_MAX, WAIT_MAX), 2 * WAIT_MAX + 4);
        // Reset during a stalled fetch abandons it, then a normal restart
        c_op = 5'(OP_NOP);
        req = base(); req.mem_read = 1'b1;
        for (int i = 0; i < 3; i++) push(req, 1'b0, rb());
        push_reset(1);
        void'(instr(5'(OP_NOP), 1'b0, 1'b0, 1, 0));
        void'(instr(5'(OP_HLT), 1'b0, 1'b0, 0, 0));
        push_halted(20);
        run();
        check_eq("hlt_halted", int'(halted), 1);
        check_eq("hlt_no_bus_err", int'(bus_err), 0);

        // Fetch never answered: fault after WAIT_MAX+1 request cycles
        push_reset(1);
        check_eq("fetch_timeout_cycles", instr(5'(OP_NOP), 1'b0, 1'b0, WAIT_MAX + 1, 0),
                 WAIT_MAX + 1);
        push_halted(6);
        run();
        check_eq("timeout_bus_err", int'(bus_err), 1);
        check_eq("timeout_halted", int'(halted), 1);
        push_reset(1);
        void'(instr(5'(OP_IN), 1'b0, 1'b0, 0, WAIT_MAX + 1));
        push_halted(3);
        push_reset(1);
        void'(instr(5'(OP_NOP), 1'b0, 1'b0, 0, 0));
        run();
        check_eq("reset_clears_bus_err", int'(bus_err), 0);

        // Random instruction stream with bounded waits
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 19);
            if (r < 15) op = 5'(legal[r]);
            else        op = 5'(16 + $urandom_range(0, 15));
            void'(instr(op, rb(), rb(),
                        ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, 3),
                        ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, 3)));
        end
        run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
